// File: rtl/srl_stage_if.sv
// -----------------------------------------------------------------------------
// srl_stage_if
//   Bundles the data/control/tap signals of the addressable shift-register
//   stage. Clock and reset stay as plain module ports.
//
//   Signals:
//     D    : serial data in (upstream block's registered Q)
//     CE   : shift enable
//     A    : tap address, 0 = newest bit
//     O    : combinational tap SR[A]
//     Q    : registered tap
//     QS   : serial out SR[DEPTH-1], for cascading
//     V    : tap A holds shifted-in data rather than INIT
//     FULL : every stage holds shifted-in data
//
//   Modports:
//     master : drives D/CE/A, observes the outputs (upstream / bench side)
//     slave  : the shift-register stage itself
// -----------------------------------------------------------------------------
interface srl_stage_if #(
    parameter int unsigned AW = 4
);
    logic          D;
    logic          CE;
    logic [AW-1:0] A;
    logic          O;
    logic          Q;
    logic          QS;
    logic          V;
    logic          FULL;

    modport master (
        output D, CE, A,
        input  O, Q, QS, V, FULL
    );

    modport slave (
        input  D, CE, A,
        output O, Q, QS, V, FULL
    );
endinterface

// File: rtl/srl_stage.sv
// -----------------------------------------------------------------------------
// srl_stage
//   Addressable shift-register stage fed by the LUT/MUX/FF block's Q output.
//   Delays D by a selectable number of cycles and tracks how far the chain has
//   been filled with real data since reset, so taps can be qualified.
//
//   Parameters:
//     DEPTH : number of shift stages (power of two, 2..32)
//     AW    : tap address width, log2(DEPTH)
//     INIT  : chain contents loaded on reset
//
//   Ports:
//     C   : clock, rising edge
//     R   : synchronous reset, active low (priority over CE)
//     bus : srl_stage_if slave modport (D, CE, A in; O, Q, QS, V, FULL out)
//
//   Only A reaches an output combinationally (O and V); D and CE act solely
//   through registered state.
// -----------------------------------------------------------------------------
module srl_stage #(
    parameter int unsigned      DEPTH = 16,
    parameter int unsigned      AW    = 4,
    parameter logic [DEPTH-1:0] INIT  = '0
) (
    input logic        C,
    input logic        R,
    srl_stage_if.slave bus
);

    // Fill counter needs AW+1 bits to represent DEPTH itself.
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);

    // Fill state, kept in step with the counter: FULL is entered on the
    // DEPTH-th enabled shift and left only through reset.
    typedef enum logic {
        ST_FILLING = 1'b0,
        ST_FULL    = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DEPTH-1:0] r_sr;
    logic [DEPTH-1:0] w_sr_nxt;
    logic [AW:0]      r_cnt;
    logic [AW:0]      w_cnt_nxt;
    logic             r_q;
    logic             w_tap;
    logic             w_valid;

    // Tap read of the current (pre-edge) chain contents.
    always_comb begin
        w_tap = r_sr[bus.A];
    end

    // A tap is valid once at least A+1 real bits have been shifted in.
    always_comb begin
        w_valid = (r_cnt > {1'b0, bus.A});
    end

    // Next-state / datapath logic.
    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;

        if (bus.CE) begin
            w_sr_nxt = {r_sr[DEPTH-2:0], bus.D};
            case (r_state)
                ST_FILLING: begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ST_FULL;
                    end
                end
                ST_FULL: begin
                    // Saturate: further shifts keep the count at DEPTH.
                    w_cnt_nxt = CNT_FULL;
                end
                default: begin
                    w_state_nxt = ST_FILLING;
                end
            endcase
        end
    end

    // State registers. The registered tap samples every edge regardless of
    // CE, using the pre-edge chain and address.
    always_ff @(posedge C) begin
        if (!R) begin
            r_state <= ST_FILLING;
            r_sr    <= INIT;
            r_cnt   <= '0;
            r_q     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_q     <= w_tap;
        end
    end

    assign bus.O    = w_tap;
    assign bus.Q    = r_q;
    assign bus.QS   = r_sr[DEPTH-1];
    assign bus.V    = w_valid;
    assign bus.FULL = (r_state == ST_FULL);

endmodule

// File: tb/tb_srl_stage.sv
// -----------------------------------------------------------------------------
// tb_srl_stage
//   Self-checking bench for srl_stage (DEPTH=16, INIT=16'hA5A5). A queue-based
//   reference model tracks the chain (index 0 = newest bit), the fill count
//   and the registered tap.
// -----------------------------------------------------------------------------
module tb_srl_stage;

    localparam int unsigned     DEPTH  = 16;
    localparam int unsigned     AW     = 4;
    localparam logic [DEPTH-1:0] INIT_V = 16'hA5A5;

    logic C;
    logic R;

    srl_stage_if #(.AW(AW)) bus ();

    srl_stage #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .INIT  (INIT_V)
    ) dut (
        .C   (C),
        .R   (R),
        .bus (bus.slave)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model
    bit m_sr[$];
    int m_cnt;
    bit m_q;

    function automatic bit exp_o(int a);
        return m_sr[a];
    endfunction

    function automatic bit exp_v(int a);
        return m_cnt > a;
    endfunction

    function automatic bit exp_qs();
        return m_sr[DEPTH-1];
    endfunction

    function automatic bit exp_full();
        return m_cnt == DEPTH;
    endfunction

    task automatic model_reset();
        m_sr.delete();
        for (int i = 0; i < DEPTH; i++) m_sr.push_back(INIT_V[i]);
        m_cnt = 0;
        m_q   = 1'b0;
    endtask

    // Drive inputs, take one rising edge, advance the model, settle 1ns.
    task automatic tick(input bit r, input bit ce, input bit d, input int a);
        R      = r;
        bus.CE = ce;
        bus.D  = d;
        bus.A  = AW'(a);
        @(posedge C);
        if (!r) begin
            model_reset();
        end else begin
            m_q = m_sr[a];
            if (ce) begin
                m_sr.push_front(d);
                m_sr.delete(DEPTH);
                if (m_cnt < DEPTH) m_cnt++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        n_checks++;
        if (bus.Q !== 1'b0) begin
            $display("FAIL reset_Q: got %b want 0", bus.Q); n_errors++;
        end
        n_checks++;
        if (bus.FULL !== 1'b0) begin
            $display("FAIL reset_FULL: got %b want 0", bus.FULL); n_errors++;
        end
        n_checks++;
        if (bus.QS !== INIT_V[DEPTH-1]) begin
            $display("FAIL reset_QS: got %b want %b", bus.QS, INIT_V[DEPTH-1]); n_errors++;
        end
        for (int a = 0; a < DEPTH; a++) begin
            bus.A = AW'(a);
            #1;
            n_checks++;
            if (bus.O !== INIT_V[a]) begin
                $display("FAIL reset_O A=%0d: got %b want %b", a, bus.O, INIT_V[a]); n_errors++;
            end
            n_checks++;
            if (bus.V !== 1'b0) begin
                $display("FAIL reset_V A=%0d: got %b want 0", a, bus.V); n_errors++;
            end
            tick(1, 0, 0, a);
            n_checks++;
            if (bus.Q !== INIT_V[a]) begin
                $display("FAIL reset_Qprev A=%0d: got %b want %b", a, bus.Q, INIT_V[a]); n_errors++;
            end
        end
    endtask

    task automatic test_delay_line();
        tick(0, 0, 0, 0);
        for (int k = 1; k <= 17; k++) begin
            tick(1, 1, (k == 1), 5);
            n_checks++;
            if (bus.O !== exp_o(5) || bus.Q !== m_q || bus.QS !== exp_qs() || bus.V !== exp_v(5)) begin
                $display("FAIL delay_model edge %0d: got O=%b Q=%b QS=%b V=%b want O=%b Q=%b QS=%b V=%b",
                         k, bus.O, bus.Q, bus.QS, bus.V, exp_o(5), m_q, exp_qs(), exp_v(5));
                n_errors++;
            end
            if (k == 5) begin
                n_checks++;
                if (bus.V !== 1'b0) begin
                    $display("FAIL delay_V_early edge 5: got %b want 0", bus.V); n_errors++;
                end
            end
            if (k == 6) begin
                n_checks++;
                if (bus.O !== 1'b1 || bus.V !== 1'b1) begin
                    $display("FAIL delay_O6 edge 6: got O=%b V=%b want O=1 V=1", bus.O, bus.V); n_errors++;
                end
            end
            if (k == 7) begin
                n_checks++;
                if (bus.Q !== 1'b1 || bus.O !== 1'b0) begin
                    $display("FAIL delay_Q7 edge 7: got Q=%b O=%b want Q=1 O=0", bus.Q, bus.O); n_errors++;
                end
            end
            if (k == 16) begin
                n_checks++;
                if (bus.QS !== 1'b1) begin
                    $display("FAIL delay_QS16 edge 16: got %b want 1", bus.QS); n_errors++;
                end
            end
            if (k == 17) begin
                n_checks++;
                if (bus.QS !== 1'b0) begin
                    $display("FAIL delay_QS17 edge 17: got %b want 0", bus.QS); n_errors++;
                end
            end
        end
    endtask

    task automatic test_fill_saturate();
        tick(0, 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            tick(1, 1, 1, $urandom_range(DEPTH-1, 0));
            n_checks++;
            if (bus.FULL !== (k >= 16)) begin
                $display("FAIL fill_FULL edge %0d: got %b want %b", k, bus.FULL, (k >= 16)); n_errors++;
            end
        end
        for (int a = 0; a < DEPTH; a++) begin
            bus.A = AW'(a);
            #1;
            n_checks++;
            if (bus.V !== 1'b1 || bus.O !== 1'b1) begin
                $display("FAIL fill_tap A=%0d: got V=%b O=%b want V=1 O=1", a, bus.V, bus.O); n_errors++;
            end
            tick(1, 0, 0, a);
        end
        n_checks++;
        if (bus.FULL !== 1'b1) begin
            $display("FAIL fill_hold: got FULL=%b want 1", bus.FULL); n_errors++;
        end
    endtask

    task automatic test_gated_shift();
        tick(0, 0, 0, 0);
        for (int k = 0; k < 8; k++) tick(1, (k % 2 == 0), 1, 0);
        bus.A = 3'(3);
        #1;
        n_checks++;
        if (bus.V !== 1'b1) begin
            $display("FAIL gated_V3: got %b want 1", bus.V); n_errors++;
        end
        bus.A = 4'(4);
        #1;
        n_checks++;
        if (bus.V !== 1'b0 || bus.FULL !== 1'b0) begin
            $display("FAIL gated_V4: got V=%b FULL=%b want V=0 FULL=0", bus.V, bus.FULL); n_errors++;
        end
        for (int a = 0; a < DEPTH; a++) begin
            bus.A = AW'(a);
            #1;
            n_checks++;
            if (bus.O !== exp_o(a) || bus.V !== (a < 4)) begin
                $display("FAIL gated_sweep A=%0d: got O=%b V=%b want O=%b V=%b",
                         a, bus.O, bus.V, exp_o(a), (a < 4));
                n_errors++;
            end
            tick(1, 0, 1, a);
        end
    endtask

    task automatic test_reset_mid();
        tick(0, 0, 0, 0);
        for (int k = 0; k < 18; k++) tick(1, 1, 1, 7);
        n_checks++;
        if (bus.FULL !== 1'b1) begin
            $display("FAIL mid_full_before: got %b want 1", bus.FULL); n_errors++;
        end
        tick(0, 1, 1, 0);
        n_checks++;
        if (bus.FULL !== 1'b0 || bus.Q !== 1'b0 || bus.V !== 1'b0 || bus.QS !== INIT_V[DEPTH-1]) begin
            $display("FAIL mid_reset: got FULL=%b Q=%b V=%b QS=%b want 0 0 0 %b",
                     bus.FULL, bus.Q, bus.V, bus.QS, INIT_V[DEPTH-1]);
            n_errors++;
        end
        bus.A = 4'(1);
        #1;
        n_checks++;
        if (bus.O !== INIT_V[1]) begin
            $display("FAIL mid_init_O1: got %b want %b", bus.O, INIT_V[1]); n_errors++;
        end
        tick(1, 1, 1, 0);
        n_checks++;
        if (bus.O !== 1'b1 || bus.V !== 1'b1) begin
            $display("FAIL mid_first_shift A=0: got O=%b V=%b want 1 1", bus.O, bus.V); n_errors++;
        end
        bus.A = 4'(1);
        #1;
        n_checks++;
        if (bus.V !== 1'b0 || bus.O !== INIT_V[0]) begin
            $display("FAIL mid_first_shift A=1: got V=%b O=%b want 0 %b", bus.V, bus.O, INIT_V[0]); n_errors++;
        end
    endtask

    task automatic test_random();
        int a2;
        tick(0, 0, 0, 0);
        for (int k = 0; k < 400; k++) begin
            tick(($urandom_range(39, 0) != 0), $urandom_range(1, 0), $urandom_range(1, 0),
                 $urandom_range(DEPTH-1, 0));
            n_checks++;
            if (bus.O !== exp_o(int'(bus.A)) || bus.Q !== m_q || bus.QS !== exp_qs() ||
                bus.V !== exp_v(int'(bus.A)) || bus.FULL !== exp_full()) begin
                $display("FAIL random step %0d A=%0d: got O=%b Q=%b QS=%b V=%b FULL=%b want %b %b %b %b %b",
                         k, bus.A, bus.O, bus.Q, bus.QS, bus.V, bus.FULL,
                         exp_o(int'(bus.A)), m_q, exp_qs(), exp_v(int'(bus.A)), exp_full());
                n_errors++;
            end
            a2 = $urandom_range(DEPTH-1, 0);
            bus.A = AW'(a2);
            #1;
            n_checks++;
            if (bus.O !== exp_o(a2) || bus.V !== exp_v(a2)) begin
                $display("FAIL random_comb step %0d A=%0d: got O=%b V=%b want %b %b",
                         k, a2, bus.O, bus.V, exp_o(a2), exp_v(a2));
                n_errors++;
            end
        end
    endtask

    initial begin
        R      = 1'b0;
        bus.CE = 1'b0;
        bus.D  = 1'b0;
        bus.A  = '0;
        model_reset();
        test_reset();
        test_delay_line();
        test_fill_saturate();
        test_gated_shift();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/srl_stage.md
# srl_stage

Addressable shift-register stage sitting directly downstream of the LUT/MUX/FF logic block: it consumes the block's registered `Q` output on its `D` input and delays it by a selectable number of cycles. Intended as the next sim model for pack-pattern experiments, where the `D -> shift chain` net is the candidate pack edge. Provides a combinational tap, a registered tap, the chain's serial output, and fill tracking so downstream logic knows when a tap holds real data.

## Interface
- `DEPTH`, 16, number of shift stages; must be a power of two between 2 and 32.
- `AW`, 4, tap address width; must equal log2(`DEPTH`).
- `INIT`, all zeros (`DEPTH` bits), contents loaded into the chain on reset.
- `C` input 1: clock, rising-edge active.
- `R` input 1: reset, synchronous, active-low.
- `D` input 1: serial data in, driven by the upstream logic block's `Q`.
- `CE` input 1: shift enable.
- `A` input `AW`: tap address; 0 is the newest bit.
- `O` output 1: combinational tap, `SR[A]`.
- `Q` output 1: registered tap.
- `QS` output 1: serial out, `SR[DEPTH-1]`; used for cascading.
- `V` output 1: tap valid, meaning `SR[A]` holds shifted-in data rather than `INIT`.
- `FULL` output 1: all `DEPTH` stages hold shifted-in data.

## Operation
- Internal state:
  - `SR[DEPTH-1:0]`.
  - Fill counter `CNT`, `AW+1` bits, range 0..`DEPTH`.
  - Output register `Q`.
- Reset (R=0 at a rising edge of C):
  - `SR <= INIT`, `CNT <= 0`, `Q <= 0`.
  - Reset has priority over `CE`.
  - Reset mid-shift discards all data, and `V` and `FULL` drop on the next edge.
- Shift (R=1 and CE=1):
  - `SR <= {SR[DEPTH-2:0], D}`.
  - If `CNT < DEPTH`, `CNT <= CNT + 1`; otherwise `CNT` saturates at `DEPTH` with no wrap.
- Hold (R=1 and CE=0): `SR` and `CNT` are unchanged.
- Registered tap (R=1): `Q <= SR[A]` on every edge regardless of `CE`, sampling the pre-edge `SR` and `A`.
- Combinational outputs:
  - `O = SR[A]`.
  - `QS = SR[DEPTH-1]`.
  - `V = (CNT > A)`.
  - `FULL = (CNT == DEPTH)`.
- State machine: two states derived from `CNT`.
  - FILLING (`CNT < DEPTH`) moves to FULL after the `DEPTH`th enabled shift.
  - FULL leaves only on reset.
  - `CE` low in FILLING simply pauses the fill.
- `A` may change every cycle. `O` and `V` follow it combinationally; `Q` follows one cycle later.

## Timing
- Values after reset, with R=0 sampled:
  - `Q=0`, `CNT=0`, `V=0`, `FULL=0`.
  - `O=INIT[A]`, `QS=INIT[DEPTH-1]`.
- Latency from `D` to `O` with `A=k` and `CE` held high: `D` sampled at edge n appears on `O` after edge n+k.
  - It appears on `Q` after edge n+k+1.
  - It appears on `QS` after edge n+`DEPTH`-1.
- `V` for tap k rises after the (k+1)th enabled shift following reset, i.e. the same edge at which the first real bit reaches `O`.
- `FULL` rises after the `DEPTH`th enabled shift.
- Simultaneous R=0 and CE=1: reset wins. `D` is not captured and `CNT` stays 0.
- The first edge with R=1 after reset may shift immediately.
- No combinational path from `D` or `CE` to any output. `A` to `O`/`V` is the only combinational path.

## Test plan
- **Reset with INIT**: `INIT=16'hA5A5`, R=0 for 2 edges, then sweep `A` 0..15 with CE=0.
  - Required: `O` equals `INIT[A]` each cycle, `V=0`, `FULL=0`, `Q=0` for the first edge.
  - Thereafter `Q` equals the previous cycle's `O`.
- **Delay line**: CE=1, A=5, drive `D` with the pattern 1,0,0,0,…
  - Required: `O=1` exactly after edge 6 (the bit was sampled at edge 1).
  - `Q=1` one edge later.
  - `V` rises after edge 6.
  - `QS=1` after edge 16.
- **Fill and saturate**: CE=1 for 20 edges, D=1.
  - Required: `FULL` rises after edge 16 and stays 1 through edge 20.
  - `CNT` is 16, with no wrap to 0.
  - `V=1` for all `A`.
- **Gated shift**: alternate CE 1,0 for 8 edges with D=1, then A=3.
  - Required: `CNT=4`, `V=1` for A=3, `V=0` for A=4.
  - `SR[3:0]=4'hF`, `SR[15:4]` still `INIT`.
- **Reset mid-operation and simultaneous events**: after a full chain, assert R=0 together with CE=1 and D=1 for one edge.
  - Required: `SR=INIT`, `CNT=0`, `FULL=0`, `Q=0` on the next cycle.
  - The next edge with R=1, CE=1, D=1 gives `O=1` for A=0 and `V=1` for A=0 only.
